stp_packer: RTL and testbench

STP_PACKER -- requirements
Module: stp_packer

---
 rtl/stp_pkg.sv | 19 +
 rtl/stp_word_fifo.sv | 73 +++++++
 rtl/stp_packer.sv | 116 +++++++++++
 tb/tb_stp_packer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stp_pkg.sv
// Shared constants and helpers for the serial-to-parallel byte packing path.
package stp_pkg;

  localparam int BYTE_W = 8;

  // Ceiling log2 for elaboration-time widths; returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stp_word_fifo.sv
// Show-ahead word FIFO: the head entry is presented whenever the FIFO is
// non-empty. Pointers carry one extra wrap bit to tell full from empty.
module stp_word_fifo
  import stp_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         iCE_CLK,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic [N-1:0] head_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] mem_d [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  // Status flags, guarded push/pop and the show-ahead head word.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    if (empty) begin
      head_data = '0;
    end else begin
      head_data = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Next pointer and storage values; pointers wrap naturally modulo 2*DEPTH.
  always_comb begin
    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers; reset empties the FIFO and zeroes storage so nothing is X.
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/stp_packer.sv
// Packs an incoming byte stream into N-bit words and queues them in a
// show-ahead FIFO. Tracks a sticky overflow flag for refused bytes.
module stp_packer
  import stp_pkg::*;
#(
  parameter int N         = 32,
  parameter int MSB_FIRST = 1,
  parameter int DEPTH     = 4
) (
  input  logic                          iCE_CLK,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          rx_valid,
  input  logic [BYTE_W-1:0]             rx_byte,
  output logic                          rx_ready,
  output logic [N-1:0]                  tx_bytes,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [clog2(N/BYTE_W)-1:0]    byte_cnt,
  output logic                          overflow
);

  localparam int BPW   = N / BYTE_W;
  localparam int CNT_W = clog2(BPW);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     part_q, part_d;
  logic             ovf_q, ovf_d;
  logic             en_q, en_d;
  logic [N-1:0]     packed_s;
  logic             accept_s;
  logic             last_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // rx_ready stays low until the first edge after reset, then follows FIFO room.
  assign rx_ready = en_q && !fifo_full_s && !clear;
  assign tx_valid = !fifo_empty_s;
  assign pop_s    = tx_valid && tx_ready;
  assign byte_cnt = cnt_q;
  assign overflow = ovf_q;

  // Shift the new byte into the partial word in the configured order.
  always_comb begin
    accept_s = rx_valid && rx_ready;
    last_s   = (cnt_q == CNT_W'(BPW - 1));
    if (MSB_FIRST != 0) begin
      packed_s = {part_q[N-BYTE_W-1:0], rx_byte};
    end else begin
      packed_s = {rx_byte, part_q[N-1:BYTE_W]};
    end
  end

  // Counter, partial word, push strobe and overflow next-state.
  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    push_s = 1'b0;
    en_d   = 1'b1;
    if (clear) begin
      cnt_d  = '0;
      part_d = '0;
    end else if (accept_s) begin
      if (last_s) begin
        cnt_d  = '0;
        part_d = '0;
        push_s = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        part_d = packed_s;
      end
    end else begin
      cnt_d  = cnt_q;
      part_d = part_q;
    end
    if (clear) begin
      ovf_d = 1'b0;
    end else if (rx_valid && !rx_ready) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Packing state registers with asynchronous reset.
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      part_q <= '0;
      ovf_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
      ovf_q  <= ovf_d;
      en_q   <= en_d;
    end
  end

  stp_word_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iCE_CLK   (iCE_CLK),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (packed_s),
    .pop       (pop_s),
    .head_data (tx_bytes),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

endmodule

// File: tb/tb_stp_packer.sv
// Directed bench: two packers (MSB-first and LSB-first) share one stimulus.
module tb_stp_packer;

  logic        iCE_CLK;
  logic        rst_n;
  logic        clear;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_ready;

  logic        rx_ready_m, tx_valid_m, overflow_m;
  logic [31:0] tx_bytes_m;
  logic [1:0]  byte_cnt_m;
  logic        rx_ready_l, tx_valid_l, overflow_l;
  logic [31:0] tx_bytes_l;
  logic [1:0]  byte_cnt_l;

  int n_checks;
  int n_errors;

  logic [31:0] fill_words [4];
  logic [31:0] run_words  [7];

  stp_packer #(.N(32), .MSB_FIRST(1), .DEPTH(4)) dut_msb (
    .iCE_CLK  (iCE_CLK),
    .rst_n    (rst_n),
    .clear    (clear),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ready (rx_ready_m),
    .tx_bytes (tx_bytes_m),
    .tx_valid (tx_valid_m),
    .tx_ready (tx_ready),
    .byte_cnt (byte_cnt_m),
    .overflow (overflow_m)
  );

  stp_packer #(.N(32), .MSB_FIRST(0), .DEPTH(4)) dut_lsb (
    .iCE_CLK  (iCE_CLK),
    .rst_n    (rst_n),
    .clear    (clear),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ready (rx_ready_l),
    .tx_bytes (tx_bytes_l),
    .tx_valid (tx_valid_l),
    .tx_ready (tx_ready),
    .byte_cnt (byte_cnt_l),
    .overflow (overflow_l)
  );

  // Free-running clock, 10 time-unit period.
  initial iCE_CLK = 1'b0;
  always #5 iCE_CLK = ~iCE_CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge iCE_CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    fill_words[0] = 32'h00010203;
    fill_words[1] = 32'h04050607;
    fill_words[2] = 32'h08090A0B;
    fill_words[3] = 32'h0C0D0E0F;
    run_words[0]  = 32'h40414243;
    run_words[1]  = 32'h44454647;
    run_words[2]  = 32'h48494A4B;
    run_words[3]  = 32'h4C4D4E4F;
    run_words[4]  = 32'h50515253;
    run_words[5]  = 32'h54555657;
    run_words[6]  = 32'h58595A5B;

    rst_n    = 1'b0;
    clear    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_ready = 1'b0;
    #12;
    // Reset values
    check_val("rst_rx_ready", {31'd0, rx_ready_m}, 32'd0);
    check_val("rst_tx_valid", {31'd0, tx_valid_m}, 32'd0);
    check_val("rst_tx_bytes", tx_bytes_m, 32'h0);
    check_val("rst_byte_cnt", {30'd0, byte_cnt_m}, 32'd0);
    check_val("rst_overflow", {31'd0, overflow_l}, 32'd0);
    @(posedge iCE_CLK);
    #1;
    rst_n = 1'b1;
    step();
    check_val("post_rst_ready", {31'd0, rx_ready_m}, 32'd1);
    check_val("post_rst_ready_l", {31'd0, rx_ready_l}, 32'd1);

    // Basic word, both byte orders, byte_cnt sequence 0,1,2,3,0
    tx_ready = 1'b1;
    check_val("cnt_seq0", {30'd0, byte_cnt_l}, 32'd0);
    send(8'hAA);
    check_val("cnt_seq1", {30'd0, byte_cnt_l}, 32'd1);
    send(8'hBB);
    check_val("cnt_seq2", {30'd0, byte_cnt_l}, 32'd2);
    send(8'hCC);
    check_val("cnt_seq3", {30'd0, byte_cnt_l}, 32'd3);
    check_val("no_early_valid", {31'd0, tx_valid_m}, 32'd0);
    send(8'hDD);
    check_val("cnt_seq4", {30'd0, byte_cnt_l}, 32'd0);
    check_val("msb_valid", {31'd0, tx_valid_m}, 32'd1);
    check_val("msb_word", tx_bytes_m, 32'hAABBCCDD);
    check_val("lsb_valid", {31'd0, tx_valid_l}, 32'd1);
    check_val("lsb_word", tx_bytes_l, 32'hDDCCBBAA);
    rx_valid = 1'b0;
    step();
    check_val("one_cycle_valid", {31'd0, tx_valid_m}, 32'd0);

    // Fill the buffer, then overflow with a 17th byte
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
    end
    check_val("full_not_ready", {31'd0, rx_ready_m}, 32'd0);
    check_val("full_head", tx_bytes_m, 32'h00010203);
    send(8'h10);
    check_val("ovf_set", {31'd0, overflow_m}, 32'd1);
    check_val("ovf_set_l", {31'd0, overflow_l}, 32'd1);
    check_val("ovf_cnt_kept", {30'd0, byte_cnt_m}, 32'd0);
    rx_valid = 1'b0;
    step();
    check_val("hold_head", tx_bytes_m, 32'h00010203);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_val("pop_order", tx_bytes_m, fill_words[k]);
      step();
    end
    check_val("drained", {31'd0, tx_valid_m}, 32'd0);
    check_val("ovf_sticky", {31'd0, overflow_m}, 32'd1);

    // Clear mid-word drops the partial word and the byte offered with it
    send(8'h11);
    send(8'h22);
    check_val("pre_clear_cnt", {30'd0, byte_cnt_m}, 32'd2);
    clear    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h33;
    #1;
    check_val("clear_not_ready", {31'd0, rx_ready_m}, 32'd0);
    step();
    clear = 1'b0;
    check_val("clear_cnt", {30'd0, byte_cnt_m}, 32'd0);
    check_val("clear_ovf", {31'd0, overflow_m}, 32'd0);
    send(8'h44);
    send(8'h55);
    send(8'h66);
    check_val("clear_no_word", {31'd0, tx_valid_m}, 32'd0);
    send(8'h77);
    check_val("clear_word_valid", {31'd0, tx_valid_m}, 32'd1);
    check_val("clear_word", tx_bytes_m, 32'h44556677);
    rx_valid = 1'b0;
    step();
    check_val("clear_single", {31'd0, tx_valid_m}, 32'd0);

    // Steady state: one word buffered, push and pop on the same edge
    for (int w = 0; w < 7; w++) begin
      for (int j = 0; j < 4; j++) begin
        rx_valid = 1'b1;
        rx_byte  = 8'(8'h40 + 4 * w + j);
        tx_ready = (w > 0) && (j == 3);
        if ((w > 0) && (j == 3)) begin
          check_val("steady_head_pre", tx_bytes_m, run_words[w-1]);
          check_val("steady_ready", {31'd0, rx_ready_m}, 32'd1);
        end
        step();
        if (j == 3) begin
          check_val("steady_valid", {31'd0, tx_valid_m}, 32'd1);
          check_val("steady_head", tx_bytes_m, run_words[w]);
        end
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    check_val("steady_last", tx_bytes_m, 32'h58595A5B);
    step();
    check_val("steady_empty", {31'd0, tx_valid_m}, 32'd0);

    // Reset with a buffered word and a partial word
    tx_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'hAA);
    send(8'hBB);
    check_val("pre_rst_cnt", {30'd0, byte_cnt_m}, 32'd2);
    check_val("pre_rst_valid", {31'd0, tx_valid_m}, 32'd1);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_val("async_valid", {31'd0, tx_valid_m}, 32'd0);
    check_val("async_cnt", {30'd0, byte_cnt_m}, 32'd0);
    check_val("async_bytes", tx_bytes_m, 32'h0);
    check_val("async_ready", {31'd0, rx_ready_m}, 32'd0);
    @(posedge iCE_CLK);
    #1;
    rst_n = 1'b1;
    step();
    check_val("rerst_ready", {31'd0, rx_ready_m}, 32'd1);
    check_val("rerst_valid", {31'd0, tx_valid_m}, 32'd0);
    tx_ready = 1'b1;
    send(8'h5A);
    send(8'h6B);
    send(8'h7C);
    send(8'h8D);
    check_val("rerst_word", tx_bytes_m, 32'h5A6B7C8D);
    check_val("rerst_word_l", tx_bytes_l, 32'h8D7C6B5A);
    rx_valid = 1'b0;
    step();
    check_val("rerst_done", {31'd0, tx_valid_m}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
